// File: rtl/alu_hs_seq_if.sv
// Operand-issue / result-consumer handshake bundle for alu_hs_seq.
// The slave side is the ALU; the master side is issue stage plus consumer.
interface alu_hs_seq_if #(
  parameter int WIDTH = 8
);
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH-1:0]   data_a_i;
  logic [WIDTH-1:0]   data_b_i;
  logic [2:0]         inst_i;
  logic               valid_o;
  logic               ready_i;
  logic [2*WIDTH-1:0] data_o;
  logic               err_o;

  modport slave (
    input  valid_i,
    input  data_a_i,
    input  data_b_i,
    input  inst_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output err_o
  );

  modport master (
    output valid_i,
    output data_a_i,
    output data_b_i,
    output inst_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  err_o
  );
endinterface

// File: rtl/alu_hs_seq.sv
// Handshaked ALU: single-cycle ops plus an iterative restoring remainder.
// Results are registered; backpressure stalls accepts while a result waits.
module alu_hs_seq #(
  parameter int WIDTH = 8
) (
  input logic        clk_p_i,
  input logic        reset_p_i,
  alu_hs_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH+1);
  localparam int RW    = 2*WIDTH;
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic {IDLE, DIV} state_t;

  state_t             state;
  logic [WIDTH-1:0]   div_a;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic [RW-1:0]      data_q;
  logic               valid_q;
  logic               err_q;

  logic               ready;
  logic               accept;
  logic               div_start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   dif;
  logic [WIDTH-1:0]   absa;
  logic [WIDTH:0]     avg_sum;
  logic [RW-1:0]      alu_res;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic [WIDTH-1:0]   rem_nx;

  assign a = bus.data_a_i;
  assign b = bus.data_b_i;

  assign ready  = (state == IDLE) &&
                  (!valid_q || bus.ready_i);
  assign accept = bus.valid_i && ready;
  assign div_start = (bus.inst_i == 3'b111) &&
                     (a != ZERO);

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.err_o   = err_q;

  always_comb begin
    sum     = b + a;
    dif     = b - a;
    avg_sum = {1'b0, a} + {1'b0, b};
    absa    = a[WIDTH-1] ? (ZERO - a) : a;
    case (bus.inst_i)
      3'b001:  alu_res = {{WIDTH{dif[WIDTH-1]}}, dif};
      3'b010:  alu_res = {ZERO, a} * {ZERO, b};
      3'b011:  alu_res = {ZERO, a & b};
      3'b100:  alu_res = {ZERO, a ^ b};
      3'b101:  alu_res = {ZERO, absa};
      3'b110:  alu_res = {ZERO, avg_sum[WIDTH:1]};
      // only reached with a==0: divide-by-zero returns b
      3'b111:  alu_res = {ZERO, b};
      default: alu_res = {{WIDTH{sum[WIDTH-1]}}, sum};
    endcase
  end

  // rem < div_a always, so the subtracted value fits WIDTH bits
  always_comb begin
    rem_sh  = {rem, div_b[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, div_a};
    if (rem_sh >= {1'b0, div_a}) begin
      rem_nx = rem_sub[WIDTH-1:0];
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      state   <= IDLE;
      div_a   <= '0;
      div_b   <= '0;
      rem     <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept && div_start) begin
            state <= DIV;
            div_a <= a;
            div_b <= b;
            rem   <= '0;
            cnt   <= CNT_W'(WIDTH);
          end else if (accept) begin
            data_q  <= alu_res;
            err_q   <= (bus.inst_i == 3'b111);
            valid_q <= 1'b1;
          end
        end
        DIV: begin
          rem   <= rem_nx;
          div_b <= div_b << 1;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            data_q  <= {ZERO, rem_nx};
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_hs_seq.sv
// Bench for alu_hs_seq (WIDTH=8): directed vectors, literal checks,
// and a queue-based reference model checked on every negedge.
module tb_alu_hs_seq;
  logic clk_p_i = 1'b0;
  logic reset_p_i;

  alu_hs_seq_if #(.WIDTH(8)) bus ();

  alu_hs_seq #(.WIDTH(8)) dut (
    .clk_p_i  (clk_p_i),
    .reset_p_i(reset_p_i),
    .bus      (bus)
  );

  always #5 clk_p_i = ~clk_p_i;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  function automatic logic [16:0] model(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    int ia = a;
    int ib = b;
    int r  = 0;
    bit e  = 0;
    case (op)
      3'd0: begin
        r = (ib + ia) % 256;
        if (r >= 128) r += 65280;
      end
      3'd1: begin
        r = (ib - ia + 256) % 256;
        if (r >= 128) r += 65280;
      end
      3'd2: r = ia * ib;
      3'd3: r = ia & ib;
      3'd4: r = ia ^ ib;
      3'd5: r = (ia >= 128) ? 256 - ia : ia;
      3'd6: r = (ia + ib) / 2;
      default: begin
        if (ia == 0) begin
          r = ib;
          e = 1;
        end else begin
          r = ib % ia;
        end
      end
    endcase
    return {e, 16'(r)};
  endfunction

  task automatic check(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboard: compare any presented result, then record new accepts.
  always @(negedge clk_p_i) begin
    if (!reset_p_i) begin
      if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got=%0h exp=none",
                   bus.data_o);
        end else begin
          check("sb_data", 32'(bus.data_o), 32'(exp_q[0][15:0]));
          check("sb_err", 32'(bus.err_o), 32'(exp_q[0][16]));
          if (bus.ready_i) void'(exp_q.pop_front());
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(model(bus.inst_i, bus.data_a_i,
                              bus.data_b_i));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    int n = 0;
    bus.valid_i  = 1'b1;
    bus.inst_i   = op;
    bus.data_a_i = a;
    bus.data_b_i = b;
    while (!bus.ready_o && n < 50) begin
      @(posedge clk_p_i); #1;
      n++;
    end
    if (!bus.ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clk_p_i); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.valid_o && lat < 40) begin
      @(posedge clk_p_i); #1;
      lat++;
    end
    if (!bus.valid_o) begin
      total++;
      bad++;
      $display("FAIL result_timeout got=0 exp=1");
    end
  endtask

  task automatic run(
    input string nm,
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [15:0] ed,
    input logic ee,
    input int el
  );
    int lat;
    issue(op, a, b);
    wait_result(lat);
    check({nm, "_data"}, 32'(bus.data_o), 32'(ed));
    check({nm, "_err"}, 32'(bus.err_o), 32'(ee));
    check({nm, "_lat"}, 32'(lat), 32'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lows;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b1;
    bus.inst_i   = 3'd0;
    bus.data_a_i = 8'h00;
    bus.data_b_i = 8'h00;
    reset_p_i    = 1'b1;
    repeat (2) @(posedge clk_p_i);
    #1 reset_p_i = 1'b0;

    check("rst_data", 32'(bus.data_o), 32'h0);
    check("rst_valid", 32'(bus.valid_o), 32'h0);
    check("rst_err", 32'(bus.err_o), 32'h0);
    check("rst_ready", 32'(bus.ready_o), 32'h1);
    @(posedge clk_p_i); #1;

    run("add_sext", 3'd0, 8'h7F, 8'h01, 16'hFF80, 1'b0, 1);
    run("mul", 3'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1);
    run("avg", 3'd6, 8'hFF, 8'hFF, 16'h00FF, 1'b0, 1);
    run("abs80", 3'd5, 8'h80, 8'h00, 16'h0080, 1'b0, 1);
    run("absFB", 3'd5, 8'hFB, 8'h11, 16'h0005, 1'b0, 1);
    run("sub", 3'd1, 8'h01, 8'h00, 16'hFFFF, 1'b0, 1);
    run("and", 3'd3, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1);
    run("xor", 3'd4, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1);

    @(posedge clk_p_i); #1;
    check("retire_valid", 32'(bus.valid_o), 32'h0);
    check("retire_hold", 32'(bus.data_o), 32'h00CC);

    // divide with ignored issue pulses while busy
    issue(3'd7, 8'h07, 8'hC8);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.ready_o) lows++;
      bus.valid_i  = 1'b1;
      bus.inst_i   = 3'(i);
      bus.data_a_i = 8'(i + 3);
      bus.data_b_i = 8'h5A;
      @(posedge clk_p_i); #1;
    end
    bus.valid_i = 1'b0;
    check("div_busy", 32'(lows), 32'd8);
    check("div_valid", 32'(bus.valid_o), 32'h1);
    check("div_data", 32'(bus.data_o), 32'h0004);
    check("div_err", 32'(bus.err_o), 32'h0);

    run("div_ff3", 3'd7, 8'h03, 8'hFF, 16'h0000, 1'b0, 9);
    run("div_big", 3'd7, 8'hFF, 8'hFE, 16'h00FE, 1'b0, 9);
    run("div_13", 3'd7, 8'h0D, 8'h64, 16'h0009, 1'b0, 9);
    run("div0", 3'd7, 8'h00, 8'h55, 16'h0055, 1'b1, 1);
    check("div0_ready", 32'(bus.ready_o), 32'h1);

    // backpressure hold then same-edge accept
    @(posedge clk_p_i); #1;
    bus.ready_i = 1'b0;
    issue(3'd2, 8'h12, 8'h34);
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(bus.ready_o), 32'h0);
      check("bp_hold", 32'(bus.data_o), 32'h03A8);
      @(posedge clk_p_i); #1;
    end
    check("bp_valid", 32'(bus.valid_o), 32'h1);
    bus.valid_i  = 1'b1;
    bus.inst_i   = 3'd4;
    bus.data_a_i = 8'h0F;
    bus.data_b_i = 8'hFF;
    bus.ready_i  = 1'b1;
    #1;
    check("bp_release", 32'(bus.ready_o), 32'h1);
    @(posedge clk_p_i); #1;
    bus.valid_i = 1'b0;
    check("bp_next", 32'(bus.data_o), 32'h00F0);

    // full-rate stream
    for (int i = 0; i < 8; i++) begin
      bus.valid_i  = 1'b1;
      bus.inst_i   = 3'(i % 7);
      bus.data_a_i = 8'(8'h93 + i * 37);
      bus.data_b_i = 8'(8'h2C + i * 91);
      check("stream_ready", 32'(bus.ready_o), 32'h1);
      @(posedge clk_p_i); #1;
    end
    bus.valid_i = 1'b0;
    repeat (2) @(posedge clk_p_i); #1;

    // reset in the middle of a divide
    issue(3'd7, 8'h07, 8'hC8);
    repeat (3) @(posedge clk_p_i);
    #1 reset_p_i = 1'b1;
    #1;
    check("mid_rst_data", 32'(bus.data_o), 32'h0);
    check("mid_rst_valid", 32'(bus.valid_o), 32'h0);
    check("mid_rst_ready", 32'(bus.ready_o), 32'h1);
    exp_q.delete();
    #1 reset_p_i = 1'b0;
    @(posedge clk_p_i); #1;
    run("post_rst_div", 3'd7, 8'h07, 8'hC8, 16'h0004, 1'b0, 9);
    run("post_rst_add", 3'd0, 8'h10, 8'h20, 16'h0030, 1'b0, 1);

    repeat (3) @(posedge clk_p_i); #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
